m_pinreduce_harness: RTL and testbench

Pin-reduction harness that lets a full-width midgetv core be placed and routed in a small package for size and timing estimates. It deserialises a 1-pin input stream into the core's `DAT_I` word and compacts up to four 32-bit core output buses into a 16-bit signature. The signature is observable on one pin, either as continuous parity or as a serial readout. It sits between package pins and `m_midgetv_core` in estimate/bring-up tops only. Its LUT cost is a known, documented constant to subtract from place/route results.

---
 rtl/m_pinreduce_harness_pkg.sv | 36 +++
 rtl/m_prh_fold.sv | 26 ++
 rtl/m_pinreduce_harness.sv | 150 +++++++++++++++
 tb/tb_m_pinreduce_harness.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_pinreduce_harness_pkg.sv
// Shared constants, readout state type and configuration cost table for the
// pin-reduction harness placed between package pins and m_midgetv_core.
package m_pinreduce_harness_pkg;

  localparam int unsigned PRH_SIGW      = 16;
  localparam int unsigned PRH_BYTEW     = 8;
  localparam int unsigned PRH_CHW       = 32;
  localparam int unsigned PRH_MODE_XOR  = 0;
  localparam int unsigned PRH_MODE_MISR = 1;
  localparam logic [PRH_SIGW-1:0] PRH_MISR_POLY = 16'h1021;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_SHIFT = 1'b1
  } prh_rd_e;

  // 4-input LUT count of one harness configuration, subtracted from
  // place/route results to recover the bare core figure.
  function automatic int unsigned prh_lut_cost(input int unsigned iwidth,
                                               input int unsigned nout,
                                               input int unsigned mode,
                                               input int unsigned hold);
    int unsigned bcw;
    int unsigned deser;
    int unsigned fold;
    int unsigned sig;
    int unsigned rdout;
    bcw   = (iwidth > 1) ? $clog2(iwidth) : 1;
    deser = bcw + 2 + ((hold != 0) ? 1 : 0);
    fold  = PRH_BYTEW * ((4 * nout + 1) / 3);
    sig   = (mode == PRH_MODE_MISR) ? PRH_SIGW + 3 : 0;
    rdout = PRH_SIGW + 4 + 6;
    return deser + fold + sig + rdout;
  endfunction

endpackage

// File: rtl/m_prh_fold.sv
// Byte-XOR fold of NOUT 32-bit core output buses down to one 8-bit value.
module m_prh_fold
  import m_pinreduce_harness_pkg::*;
#(
  parameter int unsigned NOUT = 2
) (
  input  logic [NOUT*PRH_CHW-1:0] obus_i,
  output logic [PRH_BYTEW-1:0]    fold_c
);

  logic [PRH_BYTEW-1:0] chan_f [NOUT];

  for (genvar c = 0; c < NOUT; c++) begin : g_chan
    localparam int unsigned BASE = c * PRH_CHW;
    assign chan_f[c] = obus_i[BASE+24 +: PRH_BYTEW] ^ obus_i[BASE+16 +: PRH_BYTEW]
                     ^ obus_i[BASE+8  +: PRH_BYTEW] ^ obus_i[BASE    +: PRH_BYTEW];
  end

  always_comb begin
    fold_c = '0;
    for (int unsigned c = 0; c < NOUT; c++) begin
      fold_c = fold_c ^ chan_f[c];
    end
  end

endmodule

// File: rtl/m_pinreduce_harness.sv
// Pin-reduction harness: 1-pin deserialiser feeding core DAT_I, and a 16-bit
// signature of the core output buses readable on one pin.
module m_pinreduce_harness
  import m_pinreduce_harness_pkg::*;
#(
  parameter int unsigned IWIDTH = 32,
  parameter int unsigned NOUT   = 2,
  parameter int unsigned MODE   = 1,
  parameter int unsigned HOLD   = 1
) (
  input  logic                    CLK_I,
  input  logic                    RSTN_I,
  input  logic                    sin,
  input  logic                    sin_en,
  output logic [IWIDTH-1:0]       din,
  output logic                    din_vld,
  input  logic [NOUT*PRH_CHW-1:0] obus,
  input  logic                    snap,
  output logic                    sout,
  output logic                    sout_busy
);

  localparam int unsigned BCW = (IWIDTH > 1) ? $clog2(IWIDTH) : 1;
  localparam int unsigned RCW = $clog2(PRH_SIGW);
  localparam logic [BCW-1:0] BC_LAST = BCW'(IWIDTH - 1);

  logic [IWIDTH-1:0]    sreg_q;
  logic [IWIDTH-1:0]    sreg_shift;
  logic [BCW-1:0]       bcnt_q;
  logic                 din_vld_q;
  logic                 word_done;
  logic [PRH_BYTEW-1:0] fold_c;
  logic [PRH_BYTEW-1:0] fold_q;
  logic [PRH_SIGW-1:0]  sig_q, sig_d;
  logic [PRH_SIGW-1:0]  shadow_q, shadow_d;
  logic [RCW-1:0]       rcnt_q, rcnt_d;
  prh_rd_e              rd_q, rd_d;

  // ---------------- deserialiser ----------------
  if (IWIDTH == 1) begin : g_w1
    assign sreg_shift = sin;
  end else begin : g_wn
    assign sreg_shift = {sreg_q[IWIDTH-2:0], sin};
  end

  assign word_done = (bcnt_q == BC_LAST);

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      sreg_q    <= '0;
      bcnt_q    <= '0;
      din_vld_q <= 1'b0;
    end else begin
      din_vld_q <= sin_en && word_done;
      if (sin_en) begin
        sreg_q <= sreg_shift;
        bcnt_q <= word_done ? '0 : bcnt_q + BCW'(1);
      end
    end
  end

  if (HOLD != 0) begin : g_hold
    logic [IWIDTH-1:0] din_q;
    logic              sreg_msb_unused;

    // The completed word is the post-shift value, so din lands with din_vld.
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
        din_q <= '0;
      end else if (sin_en && word_done) begin
        din_q <= sreg_shift;
      end
    end

    assign din             = din_q;
    assign sreg_msb_unused = sreg_q[IWIDTH-1];
  end else begin : g_live
    assign din = sreg_q;
  end

  assign din_vld = din_vld_q;

  // ---------------- fold and signature ----------------
  m_prh_fold #(
    .NOUT(NOUT)
  ) u_fold (
    .obus_i(obus),
    .fold_c(fold_c)
  );

  if (MODE == PRH_MODE_MISR) begin : g_misr
    assign sig_d = {sig_q[PRH_SIGW-2:0], 1'b0}
                 ^ (sig_q[PRH_SIGW-1] ? PRH_MISR_POLY : '0)
                 ^ {8'h00, fold_q};
  end else begin : g_xor
    assign sig_d = {8'h00, fold_q};
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      fold_q <= '0;
      sig_q  <= '0;
    end else begin
      fold_q <= fold_c;
      sig_q  <= sig_d;
    end
  end

  // ---------------- serial readout ----------------
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      rd_q     <= RD_IDLE;
      shadow_q <= '0;
      rcnt_q   <= '0;
    end else begin
      rd_q     <= rd_d;
      shadow_q <= shadow_d;
      rcnt_q   <= rcnt_d;
    end
  end

  // A snap that arrives while shifting is dropped, not queued.
  always_comb begin
    rd_d     = rd_q;
    shadow_d = shadow_q;
    rcnt_d   = rcnt_q;
    case (rd_q)
      RD_IDLE: begin
        if (snap) begin
          rd_d     = RD_SHIFT;
          shadow_d = sig_q;
          rcnt_d   = RCW'(PRH_SIGW - 1);
        end
      end
      RD_SHIFT: begin
        shadow_d = {shadow_q[PRH_SIGW-2:0], 1'b0};
        if (rcnt_q == '0) begin
          rd_d = RD_IDLE;
        end else begin
          rcnt_d = rcnt_q - RCW'(1);
        end
      end
      default: rd_d = RD_IDLE;
    endcase
  end

  assign sout_busy = (rd_q == RD_SHIFT);
  assign sout      = sout_busy ? shadow_q[PRH_SIGW-1] : ^sig_q;

endmodule

// File: tb/tb_m_pinreduce_harness.sv
// Bench for m_pinreduce_harness: three configurations share stimulus and are
// checked every cycle against a word/queue-level reference model.
module tb_m_pinreduce_harness;

  logic        clk;
  logic        rst_n;
  logic        sin;
  logic        sin_en;
  logic        snap;
  logic [95:0] obus;

  logic [31:0] din0;
  logic [4:0]  dinx;
  logic [0:0]  din1;
  logic        vld0, vldx, vld1;
  logic        sout0, soutx, sout1;
  logic        busy0, busyx, busy1;

  int total = 0;
  int bad   = 0;

  // configurations: 0 = 32b/2ch/MISR/hold, 1 = 5b/3ch/XOR/live, 2 = 1b/1ch/MISR/hold
  int iw   [3] = '{32, 5, 1};
  int nch  [3] = '{2, 3, 1};
  int mode [3] = '{1, 0, 1};
  int hold [3] = '{1, 0, 1};

  logic [31:0] m_acc  [3];
  logic [31:0] m_held [3];
  int          m_cnt  [3];
  logic        m_vld  [3];
  logic [7:0]  m_fold [3];
  logic [15:0] m_sig  [3];
  logic [15:0] m_rbits[3];
  int          m_left [3];

  m_pinreduce_harness #(.IWIDTH(32), .NOUT(2), .MODE(1), .HOLD(1)) dut0 (
    .CLK_I(clk), .RSTN_I(rst_n), .sin(sin), .sin_en(sin_en), .din(din0),
    .din_vld(vld0), .obus(obus[63:0]), .snap(snap), .sout(sout0), .sout_busy(busy0));

  m_pinreduce_harness #(.IWIDTH(5), .NOUT(3), .MODE(0), .HOLD(0)) dutx (
    .CLK_I(clk), .RSTN_I(rst_n), .sin(sin), .sin_en(sin_en), .din(dinx),
    .din_vld(vldx), .obus(obus[95:0]), .snap(snap), .sout(soutx), .sout_busy(busyx));

  m_pinreduce_harness #(.IWIDTH(1), .NOUT(1), .MODE(1), .HOLD(1)) dut1 (
    .CLK_I(clk), .RSTN_I(rst_n), .sin(sin), .sin_en(sin_en), .din(din1),
    .din_vld(vld1), .obus(obus[31:0]), .snap(snap), .sout(sout1), .sout_busy(busy1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] fold_of(input logic [95:0] bus, input int n);
    logic [7:0] f = 8'h00;
    for (int k = 0; k < n * 4; k++) f = f ^ bus[8*k +: 8];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = '0; m_held[i] = '0; m_cnt[i] = 0; m_vld[i] = 1'b0;
      m_fold[i] = '0; m_sig[i] = '0; m_rbits[i] = '0; m_left[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] mask;
      int          t;
      mask     = (iw[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << iw[i]) - 32'd1);
      m_vld[i] = 1'b0;
      if (sin_en) begin
        m_acc[i] = ((m_acc[i] << 1) | {31'd0, sin}) & mask;
        m_cnt[i]++;
        if (m_cnt[i] == iw[i]) begin
          m_cnt[i]  = 0;
          m_vld[i]  = 1'b1;
          m_held[i] = m_acc[i];
        end
      end
      if (mode[i] == 1) begin
        t = int'(m_sig[i]) * 2;
        if (t >= 65536) t = (t - 65536) ^ 'h1021;
        t = t ^ int'(m_fold[i]);
      end else begin
        t = int'(m_fold[i]);
      end
      if (m_left[i] > 0) m_left[i]--;
      else if (snap) begin
        m_rbits[i] = m_sig[i];
        m_left[i]  = 16;
      end
      m_fold[i] = fold_of(obus, nch[i]);
      m_sig[i]  = 16'(t);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] o_din [3];
    logic        o_vld [3];
    logic        o_sout[3];
    logic        o_busy[3];
    o_din[0] = din0;            o_din[1] = {27'd0, dinx}; o_din[2] = {31'd0, din1};
    o_vld[0] = vld0;            o_vld[1] = vldx;          o_vld[2] = vld1;
    o_sout[0] = sout0;          o_sout[1] = soutx;        o_sout[2] = sout1;
    o_busy[0] = busy0;          o_busy[1] = busyx;        o_busy[2] = busy1;
    for (int i = 0; i < 3; i++) begin
      logic        e_busy;
      logic        e_sout;
      logic [31:0] e_din;
      e_din  = (hold[i] != 0) ? m_held[i] : m_acc[i];
      e_busy = (m_left[i] > 0);
      e_sout = e_busy ? m_rbits[i][m_left[i]-1] : ^m_sig[i];
      chk($sformatf("din[%0d]", i),     o_din[i],          e_din);
      chk($sformatf("din_vld[%0d]", i), {31'd0, o_vld[i]}, {31'd0, m_vld[i]});
      chk($sformatf("sout[%0d]", i),    {31'd0, o_sout[i]}, {31'd0, e_sout});
      chk($sformatf("busy[%0d]", i),    {31'd0, o_busy[i]}, {31'd0, e_busy});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    check_all();
  endtask

  // Reset asserted between edges, held over one edge, released between edges.
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    tick();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] word;
    logic [15:0] pat;
    logic [7:0]  fs [10];
    int          npulse;
    int          n;
    bit          found;

    rst_n = 1'b1; sin = 1'b0; sin_en = 1'b0; snap = 1'b0; obus = '0;
    #1 rst_n = 1'b0;
    #11;
    model_reset();
    check_all();
    rst_n = 1'b1;

    // word capture, MSB first
    word = 32'hDEADBEEF;
    for (int b = 31; b >= 0; b--) begin
      sin = word[b]; sin_en = 1'b1;
      tick();
      if (b == 0) begin
        chk("cap_vld", {31'd0, vld0}, 32'd1);
        chk("cap_din", din0, 32'hDEADBEEF);
      end
    end
    sin_en = 1'b0;
    tick();
    chk("cap_hold", din0, 32'hDEADBEEF);

    // gapped shifting, reset after 10 shifts discards the partial word
    npulse = 0;
    for (int k = 0; k < 20; k++) begin
      sin_en = (k % 2 == 0); sin = 1'($urandom);
      tick();
      if (vld0) npulse++;
    end
    sin_en = 1'b0;
    reset_pulse();
    chk("gap_nopulse", 32'(npulse), 32'd0);
    for (int k = 1; k <= 32; k++) begin
      sin_en = 1'b1; sin = 1'($urandom);
      tick();
      if (vld0) npulse++;
      if (k == 32) chk("gap_last_vld", {31'd0, vld0}, 32'd1);
    end
    sin_en = 1'b0;
    chk("gap_onepulse", 32'(npulse), 32'd1);

    // XOR fold on the MODE 0 instance
    obus = 96'h0000_0000_0000_0000_0102_0304;
    tick();
    obus = '0;
    tick();
    chk("fold_sig", {16'd0, dutx.sig_q}, 32'h0000_0004);
    chk("fold_sout", {31'd0, soutx}, 32'd1);

    // MISR stepping from reset
    reset_pulse();
    obus = 96'h1;
    tick();
    obus = '0;
    tick();
    chk("misr_0", {16'd0, dut0.sig_q}, 32'h0001);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk($sformatf("misr_%0d", k), {16'd0, dut0.sig_q}, 32'd1 << k);
    end
    tick();
    chk("misr_wrap", {16'd0, dut0.sig_q}, 32'h1021);

    // build signature A5A5 through the MISR, then read it out
    reset_pulse();
    fs = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00};
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      obus = {88'd0, (k < 10) ? fs[k] : 8'h00};
      tick();
      if (m_sig[0] == 16'hA5A5) found = 1'b1;
    end
    obus = '0;
    chk("a5_reached", {31'd0, found}, 32'd1);
    chk("a5_sig", {16'd0, dut0.sig_q}, 32'h0000_A5A5);
    snap = 1'b1;
    tick();
    pat = 16'hA5A5;
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("rd_busy_%0d", c), {31'd0, busy0}, 32'd1);
      chk($sformatf("rd_bit_%0d", c), {31'd0, sout0}, {31'd0, pat[15-c]});
      snap = (c == 4);
      tick();
    end
    snap = 1'b0;
    chk("rd_done", {31'd0, busy0}, 32'd0);

    // reset at readout cycle 7, then a complete fresh readout
    snap = 1'b1;
    tick();
    snap = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_rd_busy", {31'd0, busy0}, 32'd0);
    chk("rst_rd_sout", {31'd0, sout0}, 32'd0);
    check_all();
    tick();
    #2 rst_n = 1'b1;
    snap = 1'b1;
    tick();
    snap = 1'b0;
    n = 0;
    while (busy0 && n < 40) begin
      n++;
      tick();
    end
    chk("rd_len", 32'(n), 32'd16);

    // randomized traffic with occasional resets
    for (int k = 0; k < 800; k++) begin
      sin    = 1'($urandom);
      sin_en = ($urandom_range(0, 3) != 0);
      snap   = ($urandom_range(0, 7) == 0);
      obus   = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 199) == 0) reset_pulse();
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
